// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART receiver.
// The slave modport belongs to the receiver. It samples rx_serial and drives
// the byte, the status pulses and the FSM state.
// The master modport belongs to whatever drives the line and consumes bytes.
// Handshake: rx_dv is a one-cycle pulse with no back-pressure. rx_byte is
// valid in the rx_dv cycle and is held until the next good frame.
// rx_frame_err is a one-cycle pulse and never coincides with rx_dv.
interface uart_rx_if;
    logic       rx_serial;
    logic [7:0] rx_byte;
    logic       rx_dv;
    logic       rx_busy;
    logic       rx_frame_err;
    logic [2:0] state;

    modport slave (
        input  rx_serial,
        output rx_byte,
        output rx_dv,
        output rx_busy,
        output rx_frame_err,
        output state
    );

    modport master (
        output rx_serial,
        input  rx_byte,
        input  rx_dv,
        input  rx_busy,
        input  rx_frame_err,
        input  state
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver.
// The receiver synchronises the line with two flops and samples each bit at
// mid-bit. A good frame updates rx_byte and pulses rx_dv.
// A low stop bit pulses rx_frame_err. The FSM then parks in BREAK until the
// line returns high.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4,
        BREAK   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             dv_q, dv_d;
    logic             err_q, err_d;
    logic [1:0]       sync_q;
    logic             rx_s;

    // Two-flop synchroniser. It resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.rx_serial};
        end
    end

    assign rx_s = sync_q[1];

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            dv_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: bit timing, start qualification and framing.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        dv_d      = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                if (clk_cnt_q == HALF_CNT) begin
                    clk_cnt_d = '0;
                    // If the line is high again at mid start bit, the low
                    // pulse was a glitch and is dropped silently.
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (clk_cnt_q == FULL_CNT) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == LAST_IDX) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (clk_cnt_q == FULL_CNT) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = CLEANUP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            CLEANUP: begin
                state_d = IDLE;
            end

            BREAK: begin
                // A stuck-low line must not look like a new start bit.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rx_byte      = byte_q;
    assign bus.rx_dv        = dv_q;
    assign bus.rx_frame_err = err_q;
    assign bus.rx_busy      = (state_q != IDLE);
    assign bus.state        = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at CLKS_PER_BIT=16. A bit-banging driver stands in for
// UART_TX. Bytes expected from good frames are queued when their frame is
// driven and popped when rx_dv fires.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_BREAK = 3'd5;

    logic clk;
    logic reset;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    int  dv_cnt    = 0;
    int  err_cnt   = 0;
    int  unexp_dv  = 0;
    int  overlap   = 0;
    int  unstable  = 0;
    bit  busy_seen = 0;
    bit  in_reset  = 1;
    time t_start   = 0;
    time t_dv      = 0;
    logic [7:0] prev_byte = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Driver tasks. Each one is entered on a falling clock edge.
    task automatic drive_bit(input logic b);
        bus.rx_serial = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        t_start = $time;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(stop);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (bus.rx_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, {31'd0, bus.rx_busy}, 32'd0);
    endtask

    // Scoreboard and monitor. Outputs are sampled on the falling edge.
    always @(negedge clk) begin
        logic [7:0] exp;
        if (bus.rx_dv && bus.rx_frame_err) overlap++;
        if (bus.rx_busy) busy_seen = 1;
        if (bus.rx_frame_err) err_cnt++;
        if (bus.rx_dv) begin
            dv_cnt++;
            t_dv = $time;
            if (exp_q.size() == 0) begin
                unexp_dv++;
            end else begin
                exp = exp_q.pop_front();
                chk("rx_byte", {24'd0, bus.rx_byte}, {24'd0, exp});
            end
        end
        if (!bus.rx_dv && bus.rx_byte !== prev_byte && !in_reset) unstable++;
        prev_byte = bus.rx_byte;
    end

    initial begin
        int dv0, err0, lat;
        logic [7:0] held;

        reset = 1'b1;
        bus.rx_serial = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_byte", {24'd0, bus.rx_byte}, 32'h00);
        chk("rst_dv",   {31'd0, bus.rx_dv}, 32'd0);
        chk("rst_busy", {31'd0, bus.rx_busy}, 32'd0);
        chk("rst_err",  {31'd0, bus.rx_frame_err}, 32'd0);
        chk("rst_state", {29'd0, bus.state}, {29'd0, ST_IDLE});
        repeat (2) @(negedge clk);
        in_reset = 0;

        // Single frame.
        exp_q.push_back(8'hF4);
        send_frame(8'hF4, 1'b1);
        wait_idle("f4", 100);
        chk("f4_dv_cnt", dv_cnt, 1);
        chk("f4_err_cnt", err_cnt, 0);

        // Back-to-back frames with no idle gap.
        exp_q.push_back(8'h12);
        exp_q.push_back(8'hA5);
        send_frame(8'h12, 1'b1);
        send_frame(8'hA5, 1'b1);
        wait_idle("b2b", 100);
        chk("b2b_dv_cnt", dv_cnt, 3);
        chk("b2b_q_empty", exp_q.size(), 0);

        // Glitch: a 4-clock low pulse must be rejected.
        dv0 = dv_cnt;
        err0 = err_cnt;
        held = bus.rx_byte;
        repeat (5) @(negedge clk);
        busy_seen = 0;
        bus.rx_serial = 1'b0;
        repeat (4) @(negedge clk);
        bus.rx_serial = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
        chk("glitch_busy_low", {31'd0, bus.rx_busy}, 32'd0);
        chk("glitch_no_dv", dv_cnt, dv0);
        chk("glitch_no_err", err_cnt, err0);
        chk("glitch_byte", {24'd0, bus.rx_byte}, {24'd0, held});

        // Framing error. The stop bit is low and the line then stays low for
        // another 40 clocks.
        held = bus.rx_byte;
        dv0 = dv_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        chk("ferr_err_cnt", err_cnt, err0 + 1);
        chk("ferr_no_dv", dv_cnt, dv0);
        chk("ferr_byte", {24'd0, bus.rx_byte}, {24'd0, held});
        chk("ferr_in_break", {29'd0, bus.state}, {29'd0, ST_BREAK});
        bus.rx_serial = 1'b1;
        repeat (6) @(negedge clk);
        chk("ferr_back_idle", {29'd0, bus.state}, {29'd0, ST_IDLE});
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        wait_idle("after_ferr", 100);
        chk("after_ferr_dv_cnt", dv_cnt, dv0 + 1);

        // Reset during data bit 4 of 8'hFF.
        dv0 = dv_cnt;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (5 * CPB + CPB / 2) @(negedge clk);
                in_reset = 1;
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("mid_rst_byte", {24'd0, bus.rx_byte}, 32'h00);
                chk("mid_rst_busy", {31'd0, bus.rx_busy}, 32'd0);
                chk("mid_rst_dv", {31'd0, bus.rx_dv}, 32'd0);
                chk("mid_rst_state", {29'd0, bus.state}, {29'd0, ST_IDLE});
                repeat (3) @(negedge clk);
                in_reset = 0;
            end
        join
        repeat (4) @(negedge clk);
        chk("mid_rst_no_dv", dv_cnt, dv0);
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1);
        wait_idle("after_rst", 100);
        chk("after_rst_dv_cnt", dv_cnt, dv0 + 1);

        // Latency from the falling start edge to rx_dv.
        dv0 = dv_cnt;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        wait_idle("lat", 100);
        chk("lat_dv_cnt", dv_cnt, dv0 + 1);
        lat = int'((t_dv - t_start) / 10);
        $display("latency %0d clk", lat);
        chk("lat_in_range", {31'd0, (lat >= 153 && lat <= 155)}, 32'd1);

        repeat (10) @(negedge clk);
        chk("unexpected_dv", unexp_dv, 0);
        chk("dv_err_overlap", overlap, 0);
        chk("byte_stability", unstable, 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
